fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end of the RV32IF pipeline. It sits directly upstream of the decode stage and drives its pc/instr inputs. The block issues word fetches to instruction memory and buffers returned words in a DEPTH-entry in-order prefetch queue. It handles redirects from branch, jal and jalr resolution by flushing the queue and discarding responses still in flight.

---
 rtl/core_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_prefetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32IF instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN, reset/NOP defaults, fetch FSM state enum, queue entry type.
package core_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 -- presented to decode whenever the fetch output is empty
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order prefetch queue of DEPTH {pc,instr} entries.
// Latency: push visible at head the cycle after the write; head is combinational.
// Backpressure: push ignored when full (no pop); caller throttles by credit.
// Ports: clk/rst (sync active-low), flush empties the queue, push/push_data,
//        pop, head (oldest entry), count/full/empty status.
module fetch_queue
   import core_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointers are AW bits wide, so DEPTH being a power of two lets them wrap for free
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues word fetches, buffers responses, feeds decode.
// Latency: rvalid to instr_valid is one cycle when the queue is empty (bypass).
// Backpressure: id_stall holds the output; requests stop once queued+in-flight reach DEPTH.
// Ports: imem_req/addr/gnt request channel, imem_rvalid/rdata in-order responses,
//        redirect_en/pc flush+restart, id_stall from decode, pc_out/instr_out/instr_valid
//        to decode, fetch_misalign pulses on an unaligned redirect target.
module fetch_prefetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              DEPTH     = 4,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
)(
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_stall,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] instr_out,
   output logic            instr_valid,
   output logic            fetch_misalign
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   outstanding, outstanding_nxt;
   logic [CW-1:0]   discard, discard_nxt;
   logic [CW-1:0]   q_count;
   logic [CW:0]     credit_used;
   logic            handshake, rsp, drop, accept, can_load;
   logic            q_push, q_pop, q_full, q_empty;
   fetch_entry_t    q_head, rsp_entry;

   assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
   assign credit_used = {1'b0, q_count} + {1'b0, outstanding};
   assign handshake   = imem_req && imem_gnt;
   // A response with nothing outstanding belongs to a request from before reset
   assign rsp         = imem_rvalid && (outstanding != '0);
   assign drop        = rsp && (redirect_en || (discard != '0));
   assign accept      = rsp && !drop;
   assign can_load    = !id_stall || !instr_valid;
   assign q_pop       = can_load && !q_empty && !redirect_en;
   // Queue is bypassed when it is empty and the output register is free
   assign q_push      = accept && !(q_empty && can_load);
   assign outstanding_nxt = outstanding + CW'(handshake) - CW'(rsp);
   // Responses return in order and a new stream starts only after every older
   // response has drained, so the PC of each kept word is the previous kept PC + 4.
   assign rsp_entry   = '{pc: rsp_pc, instr: imem_rdata};
   assign imem_addr   = fetch_pc;

   always_comb begin
      discard_nxt = discard;
      if (redirect_en)                   discard_nxt = outstanding_nxt;
      else if (rsp && (discard != '0))   discard_nxt = discard - 1'b1;
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (redirect_en && (outstanding_nxt != '0)) state_nxt = DRAIN;
         DRAIN:   state_nxt = (discard_nxt == '0) ? FETCH : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      imem_req = (state == FETCH) && !redirect_en && (credit_used < (CW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc       <= RESET_PC;
         rsp_pc         <= RESET_PC;
         outstanding    <= '0;
         discard        <= '0;
         pc_out         <= '0;
         instr_out      <= NOP_INSTR;
         instr_valid    <= 1'b0;
         fetch_misalign <= 1'b0;
      end else begin
         outstanding    <= outstanding_nxt;
         discard        <= discard_nxt;
         fetch_misalign <= redirect_en && (redirect_pc[1:0] != 2'b00);
         if (redirect_en) begin
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
         end else begin
            if (handshake) fetch_pc <= fetch_pc + 32'd4;
            if (accept)    rsp_pc   <= rsp_pc + 32'd4;
            if (can_load) begin
               if (!q_empty) begin
                  pc_out      <= q_head.pc;
                  instr_out   <= q_head.instr;
                  instr_valid <= 1'b1;
               end else if (accept) begin
                  pc_out      <= rsp_entry.pc;
                  instr_out   <= rsp_entry.instr;
                  instr_valid <= 1'b1;
               end else begin
                  instr_valid <= 1'b0;
                  instr_out   <= NOP_INSTR;
               end
            end
         end
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_en),
      .push      (q_push),
      .push_data (rsp_entry),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   // The credit check on imem_req makes a push into a full queue unreachable
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(q_push && q_full));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: memory responder + scoreboard monitor + directed stimulus.
// Latency: memory answers each grant a configurable number of cycles later, in order.
// Backpressure: imem_gnt and id_stall driven directly by the stimulus sequence.
module tb_fetch_prefetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } req_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        id_stall;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        fetch_misalign;

   req_t        inflight[$];
   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          lat     = 1;
   int          epoch   = 0;
   logic [31:0] exp_addr = 32'h0;

   always #5 clk = ~clk;

   fetch_prefetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .DEPTH     (4),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_en    (redirect_en),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .pc_out         (pc_out),
      .instr_out      (instr_out),
      .instr_valid    (instr_valid),
      .fetch_misalign (fetch_misalign)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 16'h0013} ^ 32'h00A0_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder and output monitor. Inputs change at posedge+1, everything
   // is sampled at the negedge, so each iteration sees one settled cycle.
   initial begin
      req_t r;
      exp_t e;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(inflight[0].addr);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         // decode consumes the presented word unless stalled or squashed by redirect
         if (rst && instr_valid && !id_stall && !redirect_en) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got pc %h instr %h, expected no valid output", pc_out, instr_out);
            end else begin
               e = exp_q.pop_front();
               chk("out_pc", pc_out, e.pc);
               chk("out_instr", instr_out, e.instr);
            end
         end
         if (imem_rvalid) begin
            r = inflight.pop_front();
            if (rst && !redirect_en && r.epoch == epoch)
               exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
         end
         if (!rst) begin
            epoch++;
            exp_q.delete();
            exp_addr = 32'h0;
         end else begin
            if (imem_req && imem_gnt) begin
               chk("imem_addr", imem_addr, exp_addr);
               inflight.push_back('{addr: imem_addr, due: cyc + lat, epoch: epoch});
               exp_addr = exp_addr + 32'd4;
            end
            if (redirect_en) begin
               epoch++;
               exp_q.delete();
               exp_addr = {redirect_pc[31:2], 2'b00};
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_req"},      {31'b0, imem_req},       32'h0);
      chk({tag, "_addr"},     imem_addr,               32'h0);
      chk({tag, "_pc_out"},   pc_out,                  32'h0);
      chk({tag, "_instr"},    instr_out,               NOP);
      chk({tag, "_valid"},    {31'b0, instr_valid},    32'h0);
      chk({tag, "_misalign"}, {31'b0, fetch_misalign}, 32'h0);
   endtask

   // Directed stimulus
   initial begin
      int          first_req;
      int          first_vld;
      int          nv;
      logic        got;
      logic [31:0] hold_pc;
      logic [31:0] hold_instr;

      rst = 1'b0; imem_gnt = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_reset_state("rst0");

      // streaming, 1-cycle memory latency
      tick(); rst = 1'b1; imem_gnt = 1'b1; lat = 1;
      first_req = -1; first_vld = -1;
      for (int i = 0; i < 20 && first_vld < 0; i++) begin
         @(negedge clk);
         if (imem_req && first_req < 0) first_req = cyc;
         if (instr_valid && first_vld < 0) begin
            first_vld = cyc;
            chk("first_pc", pc_out, 32'h0);
         end
      end
      chk("first_valid_latency", 32'(first_vld - first_req), 32'd2);
      nv = 0;
      repeat (8) begin
         @(negedge clk);
         if (instr_valid) nv++;
      end
      chk("steady_valid", 32'(nv), 32'd8);

      // stall: output frozen, requests stop once the queue plus in-flight reach DEPTH
      tick(); id_stall = 1'b1;
      @(negedge clk); hold_pc = pc_out; hold_instr = instr_out;
      repeat (4) @(negedge clk);
      chk("stall_pc_hold",    pc_out,                hold_pc);
      chk("stall_instr_hold", instr_out,             hold_instr);
      chk("stall_valid",      {31'b0, instr_valid},  32'h1);
      chk("stall_req_low",    {31'b0, imem_req},     32'h0);
      tick(); id_stall = 1'b0;
      repeat (10) tick();
      imem_gnt = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("drain1_all_delivered", 32'(exp_q.size()), 32'd0);

      // redirect to 0x100 with two responses in flight (latency 3)
      lat = 3;
      tick(); imem_gnt = 1'b1;
      tick();
      tick(); imem_gnt = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h100;
      tick(); redirect_en = 1'b0; imem_gnt = 1'b1;
      @(negedge clk);
      chk("drain_req_low_1", {31'b0, imem_req},       32'h0);
      chk("aligned_no_pulse", {31'b0, fetch_misalign}, 32'h0);
      chk("redirect_clears_valid", {31'b0, instr_valid}, 32'h0);
      tick(); @(negedge clk);
      chk("drain_req_low_2", {31'b0, imem_req}, 32'h0);
      tick(); @(negedge clk);
      chk("refetch_req",  {31'b0, imem_req}, 32'h1);
      chk("refetch_addr", imem_addr,         32'h100);
      for (int i = 0; i < 10 && !instr_valid; i++) @(negedge clk);
      chk("redirect_first_valid", {31'b0, instr_valid}, 32'h1);
      chk("redirect_first_pc",    pc_out,               32'h100);

      // misaligned redirect target
      lat = 1;
      repeat (6) tick();
      redirect_en = 1'b1; redirect_pc = 32'h202;
      tick(); redirect_en = 1'b0;
      @(negedge clk);
      chk("misalign_pulse", {31'b0, fetch_misalign}, 32'h1);
      chk("misalign_nop",   instr_out,               NOP);
      tick(); @(negedge clk);
      chk("misalign_one_cycle", {31'b0, fetch_misalign}, 32'h0);

      // redirect coinciding with a response while decode is stalled
      repeat (8) tick();
      id_stall = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) got = 1'b1;
      end
      chk("grant_before_redirect", {31'b0, got}, 32'h1);
      tick(); redirect_en = 1'b1; redirect_pc = 32'h300;
      tick(); redirect_en = 1'b0;
      @(negedge clk);
      chk("rv_redirect_valid", {31'b0, instr_valid}, 32'h0);
      chk("rv_redirect_nop",   instr_out,            NOP);
      tick(); id_stall = 1'b0;
      repeat (8) tick();

      // reset during DRAIN with two responses still in flight
      imem_gnt = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("drain2_all_delivered", 32'(exp_q.size()), 32'd0);
      lat = 6;
      tick(); imem_gnt = 1'b1;
      tick();
      tick(); imem_gnt = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h400;
      tick(); redirect_en = 1'b0; rst = 1'b0;
      tick();
      @(negedge clk);
      check_reset_state("rst_mid");
      tick(); rst = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("late_rvalid_no_valid", {31'b0, instr_valid}, 32'h0);
      chk("restart_req",          {31'b0, imem_req},    32'h1);
      chk("restart_addr",         imem_addr,            32'h0);
      tick(); imem_gnt = 1'b1; lat = 1;
      repeat (12) tick();
      imem_gnt = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("final_all_delivered", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench to finish");
      $fatal(1, "watchdog expired");
   end

endmodule
